// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, opcodes,
// DR select enum and the 1149.1 next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  // Opcodes; every unlisted value (incl. all ones) is BYPASS
  localparam int OP_IDCODE = 1;
  localparam int OP_USER   = 2;

  function automatic tap_state_t next_state(
    input tap_state_t s,
    input logic       tms
  );
    tap_state_t n;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PAU_DR;
      PAU_DR:  n = tms ? EX2_DR : PAU_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PAU_IR;
      PAU_IR:  n = tms ? EX2_IR : PAU_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Synchronizes tck/tms/tdi through one shared flop chain and
// derives single-clock tck rise/fall pulses from synced tck.
module jtag_tap_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_s_o,
  output logic tdi_s_o
);

  // One packed chain keeps tms/tdi aligned with tck
  logic [SYNC_STAGES-1:0][2:0] chain_q;
  logic [2:0]                  last;
  logic                        tck_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q    <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      chain_q    <= {chain_q[SYNC_STAGES-2:0],
                     {tck_i, tms_i, tdi_i}};
      tck_prev_q <= last[2];
    end
  end

  assign last       = chain_q[SYNC_STAGES-1];
  assign tck_rise_o =  last[2] & ~tck_prev_q;
  assign tck_fall_o = ~last[2] &  tck_prev_q;
  assign tms_s_o    = last[1];
  assign tdi_s_o    = last[0];

endmodule

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP responder with IDCODE/BYPASS/USER DRs;
// tck is oversampled on clock, tdo moves on tck fall.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH    = 4,
  parameter int          DR_WIDTH    = 32,
  parameter logic [31:0] IDCODE_VAL  = 32'h1A5E_A093,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [DR_WIDTH-1:0] user_dr,
  output logic                user_dr_update
);

  // Shift register wide enough for IDCODE and USER
  localparam int SW = (DR_WIDTH > 32) ? DR_WIDTH : 32;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE =
    IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USER =
    IR_WIDTH'(OP_USER);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  tap_state_t          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [SW-1:0]       dr_shift_q, dr_shift_d;
  logic [DR_WIDTH-1:0] user_dr_q, user_dr_d;
  logic                upd_q, upd_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  dr_sel_t             dr_sel;

  jtag_tap_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock      (clock),
    .reset      (reset),
    .tck_i      (tck),
    .tms_i      (tms),
    .tdi_i      (tdi),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall),
    .tms_s_o    (tms_s),
    .tdi_s_o    (tdi_s)
  );

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  // FSM: next state, only on synced tck rise
  always_comb begin
    state_d = state_q;
    if (tck_rise) state_d = next_state(state_q, tms_s);
  end

  // FSM: output targets, registered on tck fall
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state_q)
      SH_IR: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      SH_DR: begin
        tdo_d    = dr_shift_q[0];
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else if (tck_fall) begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_en_unused_guard(tdo_en_d);
    end
  end

  function automatic logic tdo_en_en_unused_guard(input logic v);
    return v;
  endfunction

  always_comb begin
    unique case (1'b1)
      (ir_q == IR_IDCODE): dr_sel = DR_IDCODE;
      (ir_q == IR_USER):   dr_sel = DR_USER;
      default:             dr_sel = DR_BYPASS;
    endcase
  end

  // Register actions fire on the rise leaving a state
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    dr_shift_d = dr_shift_q;
    user_dr_d  = user_dr_q;
    upd_d      = 1'b0;
    if (tck_rise) begin
      case (state_q)
        CAP_IR: ir_shift_d = IR_WIDTH'(1);
        SH_IR:  ir_shift_d = {tdi_s,
                              ir_shift_q[IR_WIDTH-1:1]};
        UPD_IR: ir_d = ir_shift_q;
        CAP_DR: begin
          case (dr_sel)
            DR_IDCODE: dr_shift_d = SW'(IDCODE_VAL);
            DR_USER:   dr_shift_d = SW'(user_dr_q);
            default:   dr_shift_d = '0;
          endcase
        end
        SH_DR: begin
          // tdi enters at the MSB of the selected length
          case (dr_sel)
            DR_IDCODE: begin
              dr_shift_d     = dr_shift_q >> 1;
              dr_shift_d[31] = tdi_s;
            end
            DR_USER: begin
              dr_shift_d               = dr_shift_q >> 1;
              dr_shift_d[DR_WIDTH-1]   = tdi_s;
            end
            default: begin
              dr_shift_d    = '0;
              dr_shift_d[0] = tdi_s;
            end
          endcase
        end
        UPD_DR: begin
          if (dr_sel == DR_USER) begin
            user_dr_d = dr_shift_q[DR_WIDTH-1:0];
            upd_d     = 1'b1;
          end
        end
        default: ;
      endcase
      if (state_d == TLR) ir_d = IR_IDCODE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
      dr_shift_q <= '0;
      user_dr_q  <= '0;
      upd_q      <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      dr_shift_q <= dr_shift_d;
      user_dr_q  <= user_dr_d;
      upd_q      <= upd_d;
    end
  end

  assign tdo            = tdo_q;
  assign tdo_en         = tdo_en_q;
  assign tap_state      = state_q;
  assign ir_value       = ir_q;
  assign user_dr        = user_dr_q;
  assign user_dr_update = upd_q;

endmodule
